// File: rtl/seq_detector_pkg.sv
// Shared definitions for the runtime-programmable serial sequence detector:
// control-state encoding, length-field width helper and length-to-mask function.
package seq_detector_pkg;

  // FILL: fewer than len valid history bits; DETECT: enough bits to compare.
  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_DETECT = 1'b1
  } state_e;

  // Width of a field that must hold the values 0..max_w inclusive.
  function automatic int len_w(input int max_w);
    return $clog2(max_w + 1);
  endfunction

  // Mask selecting the len most recent history bits (bit 0 = newest).
  function automatic logic [31:0] len_to_mask(input logic [31:0] len);
    if (len >= 32'd32) begin
      return '1;
    end
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Bus between a serial bit source / configuration master and the detector.
// Handshake: din is consumed on every clock edge where din_valid is high and
// cfg_load is low; there is no ready, the detector always accepts. cfg_load is
// a one-cycle strobe and takes priority over din_valid in the same cycle.
interface seq_detector_if
  import seq_detector_pkg::*;
#(
  parameter int MAX_W   = 8,
  parameter int COUNT_W = 8
);
  localparam int LEN_W = len_w(MAX_W);

  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_W-1:0]   cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic               busy_fill;
  logic [COUNT_W-1:0] match_count;
  state_e             dbg_state;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, busy_fill, match_count, dbg_state
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, busy_fill, match_count, dbg_state
  );
endinterface

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear (clear beats increment).
module seq_match_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [COUNT_W-1:0] o_count
);
  logic [COUNT_W-1:0] r_count;

  // Count match pulses, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector (pattern, length, overlap).
// Optional match counter enabled by defining SEQDET_MATCH_COUNT_EN; without it
// match_count reads 0 and cnt_clr is ignored.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               MAX_W       = 8,
  parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(8'b0000_1011),
  parameter int               DEF_LEN     = 4,
  parameter int               COUNT_W     = 8
) (
  input logic            clk,
  input logic            rst_n,
  seq_detector_if.slave  bus
);
  localparam int             LEN_W     = len_w(MAX_W);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(DEF_LEN);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [MAX_W-1:0] r_pattern, w_pattern_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic             r_overlap, w_overlap_next;
  logic [MAX_W-1:0] r_hist, w_hist_next, w_hist_acc, w_mask;
  logic [LEN_W-1:0] r_fill, w_fill_next, w_fill_acc, w_len_cfg;
  logic             r_match, w_match_next, w_hit;
  logic             r_busy, w_busy_next;
  state_e           r_state, w_state_next;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Candidate history/fill for an accepted bit and the resulting compare.
  always_comb begin
    w_mask     = MAX_W'(len_to_mask(32'(r_len)));
    w_hist_acc = {r_hist[MAX_W-2:0], bus.din};
    w_fill_acc = (r_fill == MAX_LEN) ? MAX_LEN : r_fill + 1'b1;
    w_hit      = (((w_hist_acc ^ r_pattern) & w_mask) == '0) && (w_fill_acc >= r_len);
    w_len_cfg  = (bus.cfg_len == '0) ? LEN_W'(1) :
                 (bus.cfg_len > MAX_LEN) ? MAX_LEN : bus.cfg_len;
  end

  // Control FSM next state plus datapath next values.
  always_comb begin
    w_pattern_next = r_pattern;
    w_len_next     = r_len;
    w_overlap_next = r_overlap;
    w_hist_next    = r_hist;
    w_fill_next    = r_fill;
    w_match_next   = 1'b0;
    w_state_next   = r_state;
    if (bus.cfg_load) begin
      w_pattern_next = bus.cfg_pattern;
      w_len_next     = w_len_cfg;
      w_overlap_next = bus.cfg_overlap;
      w_hist_next    = '0;
      w_fill_next    = '0;
      w_state_next   = ST_FILL;
    end else if (bus.din_valid) begin
      w_hist_next  = w_hist_acc;
      w_match_next = w_hit;
      // A non-overlapping match restarts filling from scratch.
      w_fill_next  = (w_hit && !r_overlap) ? '0 : w_fill_acc;
      w_state_next = (w_fill_next >= r_len) ? ST_DETECT : ST_FILL;
    end
    w_busy_next = (w_state_next == ST_FILL);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= DEF_LEN_C;
      r_overlap <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_busy    <= 1'b1;
      r_state   <= ST_FILL;
    end else begin
      r_pattern <= w_pattern_next;
      r_len     <= w_len_next;
      r_overlap <= w_overlap_next;
      r_hist    <= w_hist_next;
      r_fill    <= w_fill_next;
      r_match   <= w_match_next;
      r_busy    <= w_busy_next;
      r_state   <= w_state_next;
    end
  end

  assign bus.match     = r_match;
  assign bus.busy_fill = r_busy;
  assign bus.dbg_state = r_state;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [COUNT_W-1:0] w_count;

  seq_match_counter #(.COUNT_W(COUNT_W)) u_match_counter (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_inc   (r_match),
    .i_clr   (bus.cnt_clr),
    .o_count (w_count)
  );
  assign bus.match_count = w_count;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = bus.cnt_clr;
  assign bus.match_count  = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed scenarios then random traffic,
// compared against a queue-based model of the detector behaviour.
module tb_seq_detector_param;
  import seq_detector_pkg::*;

  localparam int MAX_W   = 8;
  localparam int COUNT_W = 2;
  localparam int LEN_W   = len_w(MAX_W);
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_detector_if #(.MAX_W(MAX_W), .COUNT_W(COUNT_W)) bus ();

  seq_detector_param #(
    .MAX_W       (MAX_W),
    .DEF_PATTERN (8'b0000_1011),
    .DEF_LEN     (4),
    .COUNT_W     (COUNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_hist[i] is the bit received i accepts ago.
  bit               m_hist[$];
  int               m_fresh;
  int               m_len;
  logic [MAX_W-1:0] m_pat;
  bit               m_ovl;
  bit               m_match;
  int               m_count;

  task automatic model_reset();
    m_hist.delete();
    m_fresh = 0;
    m_len   = 4;
    m_pat   = 8'b0000_1011;
    m_ovl   = 1'b1;
    m_match = 1'b0;
    m_count = 0;
  endtask

  task automatic model_clock(input logic v, input logic d, input logic ld,
                             input logic [MAX_W-1:0] pat, input int len,
                             input logic ovl, input logic clr);
    bit hit;
`ifdef SEQDET_MATCH_COUNT_EN
    if (clr) m_count = 0;
    else if (m_match && m_count < CNT_MAX) m_count++;
`endif
    m_match = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > MAX_W) ? MAX_W : len);
      m_ovl = ovl;
      m_hist.delete();
      m_fresh = 0;
    end else if (v) begin
      m_hist.push_front(d);
      if (m_hist.size() > MAX_W) void'(m_hist.pop_back());
      m_fresh++;
      hit = (m_fresh >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (i >= m_hist.size() || m_hist[i] != m_pat[i]) hit = 1'b0;
      end
      if (hit) begin
        m_match = 1'b1;
        if (!m_ovl) m_fresh = 0;
      end
    end
  endtask

  // Scoreboard checks
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_busy;
    exp_busy = (m_fresh < m_len);
    check_val({tag, ".match"}, 32'(bus.match), 32'(m_match));
    check_val({tag, ".busy"}, 32'(bus.busy_fill), 32'(exp_busy));
    check_val({tag, ".count"}, 32'(bus.match_count), 32'(m_count));
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic drive(input string tag, input logic v, input logic d, input logic ld,
                       input logic [MAX_W-1:0] pat, input int len,
                       input logic ovl, input logic clr);
    bus.din_valid   = v;
    bus.din         = d;
    bus.cfg_load    = ld;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
    bus.cnt_clr     = clr;
    @(posedge clk);
    model_clock(v, d, ld, pat, len, ovl, clr);
    #1;
    check_outputs(tag);
  endtask

  task automatic bit_in(input string tag, input logic d);
    drive(tag, 1'b1, d, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [MAX_W-1:0] pat, input int len,
                      input logic ovl);
    drive(tag, 1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
  endtask

  task automatic stream(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(tag, bits[i]);
  endtask

  // Pulse reset mid-cycle, check outputs at once, release, wait out synchroniser.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle({tag, ".sync"}, 2);
  endtask

  initial begin
    int r;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.din_valid = 1'b0; bus.din = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    idle("rst_release", 2);

    // Default config, overlapping: 1011011 -> matches after bits 4 and 7.
    stream("dflt", 16'b1011011, 7);
    idle("dflt_idle", 2);
`ifdef SEQDET_MATCH_COUNT_EN
    check_val("dflt_count", 32'(bus.match_count), 32'd2);
`else
    check_val("dflt_count", 32'(bus.match_count), 32'd0);
`endif

    // Non-overlapping: only the first match.
    load("nov_cfg", 8'b1011, 4, 1'b0);
    stream("nov", 16'b1011011, 7);
    idle("nov_idle", 2);

    // Gapped valid strobes.
    load("gap_cfg", 8'b1011, 4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      r = (i == 2) ? 0 : 1;
      bit_in("gap_bit", logic'(r));
      idle("gap_idle", 3);
    end

    // cfg_load mid-sequence drops the concurrent bit.
    stream("mid_pre", 16'b101, 3);
    drive("mid_load", 1'b1, 1'b1, 1'b1, 8'b11, 2, 1'b1, 1'b0);
    stream("mid_post", 16'b11, 2);
    // Length 0 is treated as 1; also clamp of an oversize length.
    load("len0_cfg", 8'b1, 0, 1'b1);
    stream("len0", 16'b1011, 4);
    load("lenbig_cfg", 8'hA5, 15, 1'b1);
    stream("lenbig", 16'hA5A5, 16);

    // Saturation, then clear coinciding with a match pulse.
    load("sat_cfg", 8'b1, 1, 1'b1);
    drive("sat_clr0", 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
    stream("sat", 16'b11111, 5);
    idle("sat_idle", 1);
`ifdef SEQDET_MATCH_COUNT_EN
    check_val("sat_count", 32'(bus.match_count), 32'(CNT_MAX));
`endif
    bit_in("sat_more", 1'b1);
    drive("sat_clr", 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    idle("sat_after", 2);

    // Async reset between bits 3 and 4 of 1011.
    load("rst_cfg", 8'b1011, 4, 1'b1);
    stream("rst_pre", 16'b101, 3);
    async_reset("rst_mid");
    bit_in("rst_post", 1'b1);
    idle("rst_post_idle", 2);

    // Random traffic with occasional reconfiguration and clears.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        load("rnd_cfg", MAX_W'($urandom), ($urandom_range(0, 3) == 0) ?
             $urandom_range(0, 15) : $urandom_range(1, 4), logic'($urandom_range(0, 1)));
      end else begin
        drive("rnd", logic'(r < 75), logic'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0,
              logic'($urandom_range(0, 39) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, runtime-programmable serial bit-sequence detector. It is the successor to the fixed-pattern 1011 Mealy detector.
- Pattern value, pattern length (1..MAX_W) and overlap/non-overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe.
- Sits between a serial bit source (switch/debounced input or UART-derived stream) and LED/status logic on the Mimas V2 board.

Parameters:
MAX_W, 8, maximum pattern length in bits (2..32)
DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB = most recent bit)
DEF_LEN, 4, pattern length loaded at reset
COUNT_W, 8, width of match counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
din_valid  in  1  din sampled this cycle when high
din  in  1  serial input bit
cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  in  MAX_W  new pattern, bit 0 = last bit of sequence
cfg_len  in  $clog2(MAX_W+1)  new pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cnt_clr  in  1  synchronous clear of match_count
match  out  1  one-cycle pulse per detected sequence
busy_fill  out  1  high while history holds fewer than len valid bits
match_count  out  COUNT_W  number of matches since reset/clear

Behaviour:
- Reset (async, rst_n low), all values take effect immediately:
  - pattern_r = DEF_PATTERN, len_r = DEF_LEN, overlap_r = 1
  - hist = 0, fill = 0
  - match = 0, match_count = 0, busy_fill = 1
- Release of rst_n is synchronised internally (2-flop) before it affects the registers.
- Accept cycle = din_valid high and cfg_load low:
  - hist_next = {hist[MAX_W-2:0], din}
  - fill_next = min(fill+1, MAX_W)
- Match condition: (hist_next & mask) == (pattern_r & mask) AND fill_next >= len_r, where mask = (1<<len_r)-1.
- Latency: match is registered and pulses high for exactly one cycle, on the cycle after the accept cycle that completed the sequence. match = 0 in every other cycle, including non-valid cycles.
- Overlap mode: hist/fill are unaffected by a match, so suffix reuse is allowed.
- Non-overlap mode: on a match, fill_next = 0, so the next match needs len_r fresh bits.
- cfg_load:
  - Latches the new config.
  - Clears hist and fill, and cancels any pending match (match = 0 next cycle).
  - Same cycle as din_valid: cfg_load wins and that din is dropped.
- cfg_len clamping: 0 is treated as 1; values > MAX_W are clamped to MAX_W.
- busy_fill = (fill < len_r), registered.
- State machine (control): FILL (fill < len_r) -> DETECT (fill >= len_r).
  - DETECT -> FILL on cfg_load.
  - DETECT -> FILL on a non-overlap match.
- din_valid low: no state change.

Optional Feature:
Macro SEQDET_MATCH_COUNT_EN.
- Defined:
  - match_count increments on each match pulse and saturates at 2^COUNT_W-1.
  - cnt_clr clears it to 0 next cycle; cnt_clr has priority over a simultaneous increment.
  - cfg_load does not clear the count.
- Undefined: match_count is tied to 0, cnt_clr is ignored, and no counter flops are inferred.

Decomposition:
- Package seq_detector_pkg holds:
  - state encoding constants (ST_FILL = 1'b0, ST_DETECT = 1'b1)
  - the LEN_W = $clog2(MAX_W+1) computation helper
  - the length-to-mask function
- One natural sub-module: seq_match_counter (saturating counter with clear), instantiated only under SEQDET_MATCH_COUNT_EN.

Test Plan:
- Reset defaults (len 4, pattern 1011, overlap): stream 1,0,1,1,0,1,1 one bit per cycle -> match pulses one cycle after bits 4 and 7; match_count = 2.
- Non-overlap via cfg_load (pattern 1011, len 4, overlap 0): same stream -> single match after bit 4 only; busy_fill high during bits 5-7.
- Gapped valid: 1,0,1,1 with din_valid low for 3 cycles between each bit -> exactly one match, one cycle after the 4th valid bit; no match on idle cycles.
- cfg_load mid-sequence: feed 1,0,1 then cfg_load (pattern 11, len 2) in the same cycle as din_valid=1 -> that bit is dropped, fill = 0; then 1,1 -> match after the 2nd bit; cfg_len = 0 treated as 1 (pattern 1 matches every 1).
- Saturation (COUNT_W = 2, macro on): 5 matches -> match_count sticks at 3; cnt_clr asserted together with a match -> count = 0.
- Async reset mid-stream: rst_n low between bits 3 and 4 of 1011 -> outputs zero immediately; after release, feeding just 1 -> no match.
